lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter: MEM_BYTES, 256, byte size of the data memory; addresses at or above it fault.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req_valid  in  1  pipeline presents a load/store request.
REQ-005 SHALL have port: req_ready  out  1  block accepts a request this cycle.
REQ-006 SHALL have port: req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_funct3  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have port: req_addr  in  32  byte address.
REQ-009 SHALL have port: req_wdata  in  32  store data.
REQ-010 SHALL have port: rsp_valid  out  1  response available.
REQ-011 SHALL have port: rsp_ready  in  1  pipeline consumes the response.
REQ-012 SHALL have port: rsp_rdata  out  32  load result; 0 for stores and faults.
REQ-013 SHALL have port: rsp_err  out  2  00 ok, 01 misaligned, 10 out-of-range, 11 illegal funct3.
REQ-014 SHALL have ports to data memory: dmem_addr out 32, dmem_wr_data out 32, dmem_wr out 1, dmem_rd out 1, dmem_mask out 3, dmem_rdata in 32; memory reads combinationally and writes on falling clk.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-016 SHALL accept on rising edge when req_valid && req_ready, registering we, funct3, addr, wdata.
REQ-017 SHALL check on acceptance, in priority order: illegal funct3 (011, 110, 111; store with funct3[2]=1) -> 11; misaligned (H/HU addr[0]=1, W addr[1:0]!=00) -> 01; addr+size > MEM_BYTES -> 10.
REQ-018 SHALL go IDLE -> RESP directly on a faulting request, no dmem activity, rsp_rdata = 0.
REQ-019 SHALL, in ACCESS, drive dmem_addr/dmem_wr_data/dmem_mask from registered request, dmem_rd = !we, dmem_wr = we; all dmem strobes 0 in every other state.
REQ-020 SHALL capture dmem_rdata into rsp_rdata at the rising edge ending ACCESS (loads), then enter RESP.
REQ-021 SHALL hold rsp_valid = 1 and all rsp_* stable in RESP until rsp_ready = 1; return to IDLE on that edge.
REQ-022 SHALL give latency: accept at edge N, rsp_valid high from edge N+2 (good access) or N+1 (fault).
REQ-023 SHALL ignore req_valid outside IDLE; no request queued; back-to-back throughput one request per 3 cycles.
REQ-024 SHALL decode dmem_wr combinationally from state so that reset de-asserts it before the pending falling edge.

Reset
REQ-025 SHALL, on rst, immediately force IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 00, dmem_wr = 0, dmem_rd = 0, dmem_addr = 0, dmem_wr_data = 0, dmem_mask = 000.
REQ-026 SHALL drop an in-flight request on reset mid-ACCESS or mid-RESP with no response and no memory write.

Configuration
REQ-027 SHALL, with LSU_PERF_CNT_EN defined, add outputs load_cnt, store_cnt, fault_cnt (16 bits each), incremented on entering RESP by type, saturating at FFFF, cleared by rst.
REQ-028 SHALL, without LSU_PERF_CNT_EN, omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-029 SHALL cover: store W 0xDEADBEEF to 0x10, then load W 0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 00, rsp_valid 2 cycles after each accept.
REQ-030 SHALL cover: word 0x000080F0 at 0x20; LB 0x20 -> 0xFFFFFFF0; LBU 0x20 -> 0x000000F0; LH 0x20 -> 0xFFFF80F0.
REQ-031 SHALL cover: LW 0x22 -> err 01; SH 0x21 -> err 01; LW 0x100 -> err 10; funct3 011 -> err 11; each 1 cycle after accept, dmem_wr never high, memory unchanged.
REQ-032 SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready 0, extra req_valid ignored.
REQ-033 SHALL cover: rst asserted during ACCESS of store 0x12345678 to 0x30 before falling edge -> word 0x30 keeps old value, outputs at reset values.
REQ-034 SHALL cover (LSU_PERF_CNT_EN): 2 loads, 1 store, 1 fault -> load_cnt 2, store_cnt 1, fault_cnt 1.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between the pipeline and a byte-addressed data memory.
// Each request is checked on acceptance. A faulting request goes straight to RESP. A legal one
// spends exactly one cycle in ACCESS, driving the memory, and then enters RESP.
//
// Ports
//   clk, rst          : single clock, asynchronous active-high reset
//   req_*             : request handshake (valid/ready), store flag, RV32I funct3, address, store data
//   rsp_*             : response handshake (valid/ready), load data, error code
//                       (00 ok, 01 misaligned, 10 out of range, 11 illegal funct3)
//   dmem_addr         : byte address of the access
//   dmem_wr_data      : store data, unshifted (the memory takes the low bytes)
//   dmem_mask         : access size: 001 byte, 011 half, 111 word
//   dmem_rd, dmem_wr  : access strobes, high only in ACCESS
//   dmem_rdata        : aligned 32-bit word holding dmem_addr, returned combinationally
//   load_cnt, store_cnt, fault_cnt : saturating event counters, present only when
//                       LSU_PERF_CNT_EN is defined
//
// The dmem_*, req_ready and rsp_valid outputs are decoded from the state register. An
// asynchronous reset therefore clears them at once, including a pending falling-edge write.
module lsu_ctrl #(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wr_data,
    output logic        dmem_wr,
    output logic        dmem_rd,
    output logic [2:0]  dmem_mask,
    input  logic [31:0] dmem_rdata
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [15:0] load_cnt,
    output logic [15:0] store_cnt,
    output logic [15:0] fault_cnt
`endif
);

    localparam int unsigned ADDR_W = 32;
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_FUNCT3   = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t state, state_nxt;

    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic            accept;
    logic            acc_illegal;
    logic            acc_misaligned;
    logic            acc_range;
    logic [2:0]      acc_size;
    logic [ADDR_W:0] acc_end;
    logic [1:0]      acc_err;
    logic [31:0]     rd_shift;
    logic [31:0]     load_data;

    assign accept = (state == IDLE) && req_valid;

    // Request checks on the incoming fields. The end address is one bit wider, so a
    // request near the top of the 32-bit space cannot wrap round into range.
    always_comb begin
        acc_illegal = 1'b0;
        acc_size    = 3'd1;
        case (req_funct3)
            3'b000, 3'b100: acc_size = 3'd1;
            3'b001, 3'b101: acc_size = 3'd2;
            3'b010:         acc_size = 3'd4;
            default:        acc_illegal = 1'b1;
        endcase
        if (req_we && req_funct3[2]) begin
            acc_illegal = 1'b1;
        end
        acc_misaligned = ((acc_size == 3'd2) && req_addr[0])
                      || ((acc_size == 3'd4) && (req_addr[1:0] != 2'b00));
        acc_end   = {1'b0, req_addr} + (ADDR_W + 1)'(acc_size);
        acc_range = acc_end > MEM_LIMIT;
        if (acc_illegal) begin
            acc_err = ERR_FUNCT3;
        end else if (acc_misaligned) begin
            acc_err = ERR_MISALIGN;
        end else if (acc_range) begin
            acc_err = ERR_RANGE;
        end else begin
            acc_err = ERR_OK;
        end
    end

    // Select the addressed lane out of the aligned word, then sign- or zero-extend it.
    always_comb begin
        rd_shift = dmem_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  load_data = {24'h000000, rd_shift[7:0]};
            3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  load_data = {16'h0000, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_nxt    = state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        dmem_addr    = 32'h0;
        dmem_wr_data = 32'h0;
        dmem_wr      = 1'b0;
        dmem_rd      = 1'b0;
        dmem_mask    = 3'b000;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = (acc_err != ERR_OK) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                dmem_addr    = addr_q;
                dmem_wr_data = wdata_q;
                dmem_wr      = we_q;
                dmem_rd      = !we_q;
                case (funct3_q[1:0])
                    2'b00:   dmem_mask = 3'b001;
                    2'b01:   dmem_mask = 3'b011;
                    default: dmem_mask = 3'b111;
                endcase
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture and response data. rsp_rdata starts at zero on acceptance and is
    // overwritten only by a load leaving ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= ERR_OK;
        end else if (accept) begin
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rsp_rdata <= 32'h0;
            rsp_err   <= acc_err;
        end else if ((state == ACCESS) && !we_q) begin
            rsp_rdata <= load_data;
        end
    end

`ifdef LSU_PERF_CNT_EN
    // Count events as they enter RESP: faults from IDLE, good loads and stores from ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt  <= 16'h0;
            store_cnt <= 16'h0;
            fault_cnt <= 16'h0;
        end else begin
            if (accept && (acc_err != ERR_OK) && (fault_cnt != 16'hFFFF)) begin
                fault_cnt <= fault_cnt + 16'd1;
            end
            if ((state == ACCESS) && !we_q && (load_cnt != 16'hFFFF)) begin
                load_cnt <= load_cnt + 16'd1;
            end
            if ((state == ACCESS) && we_q && (store_cnt != 16'hFFFF)) begin
                store_cnt <= store_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl. A byte-array memory model answers dmem reads and applies
// writes on the falling edge. Expected responses are queued as each request is driven and are
// compared when rsp_valid rises.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wr_data;
    logic        dmem_wr;
    logic        dmem_rd;
    logic [2:0]  dmem_mask;
    logic [31:0] dmem_rdata;
`ifdef LSU_PERF_CNT_EN
    logic [15:0] load_cnt;
    logic [15:0] store_cnt;
    logic [15:0] fault_cnt;
    int          n_load;
    int          n_store;
    int          n_fault;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp;
    int         n_err;
    int         wr_cnt;
    logic [7:0] mem [0:255];

    lsu_ctrl #(.MEM_BYTES(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .dmem_addr    (dmem_addr),
        .dmem_wr_data (dmem_wr_data),
        .dmem_wr      (dmem_wr),
        .dmem_rd      (dmem_rd),
        .dmem_mask    (dmem_mask),
        .dmem_rdata   (dmem_rdata)
`ifdef LSU_PERF_CNT_EN
        ,
        .load_cnt     (load_cnt),
        .store_cnt    (store_cnt),
        .fault_cnt    (fault_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational aligned-word read; falling-edge write of the low bytes.
    always_comb begin
        logic [7:0] base;
        base = {dmem_addr[7:2], 2'b00};
        dmem_rdata = {mem[base + 8'd3], mem[base + 8'd2], mem[base + 8'd1], mem[base]};
    end

    always @(negedge clk) begin
        if (dmem_wr) begin
            wr_cnt <= wr_cnt + 1;
            mem[dmem_addr[7:0]] <= dmem_wr_data[7:0];
            if (dmem_mask[1]) mem[dmem_addr[7:0] + 8'd1] <= dmem_wr_data[15:8];
            if (dmem_mask[2]) begin
                mem[dmem_addr[7:0] + 8'd2] <= dmem_wr_data[23:16];
                mem[dmem_addr[7:0] + 8'd3] <= dmem_wr_data[31:24];
            end
        end
    end

    function automatic logic [31:0] mem_word(input int a);
        return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_dmem_wr"}, 32'(dmem_wr), 32'd0);
        check({tag, "_dmem_rd"}, 32'(dmem_rd), 32'd0);
        check({tag, "_dmem_addr"}, dmem_addr, 32'h0);
        check({tag, "_dmem_wr_data"}, dmem_wr_data, 32'h0);
        check({tag, "_dmem_mask"}, 32'(dmem_mask), 32'd0);
    endtask

    // One request. The response must appear 2 cycles after accept (1 for a fault). It is
    // then held for `hold` cycles under back-pressure while a stray request is offered.
    task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] erd, input logic [1:0] eerr, input int hold);
        exp_t e;
        int   lat;
        int   exp_lat;
        logic [2:0] exp_mask;
        exp_q.push_back('{rdata: erd, err: eerr});
        exp_lat  = (eerr != 2'b00) ? 1 : 2;
        exp_mask = (f3[1:0] == 2'b00) ? 3'b001 : (f3[1:0] == 2'b01) ? 3'b011 : 3'b111;
`ifdef LSU_PERF_CNT_EN
        if (eerr != 2'b00) n_fault++;
        else if (we) n_store++;
        else n_load++;
`endif
        @(negedge clk);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 9;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1 && eerr == 2'b00) begin
                check({tag, "_dmem_rd"}, 32'(dmem_rd), 32'(!we));
                check({tag, "_dmem_wr"}, 32'(dmem_wr), 32'(we));
                check({tag, "_dmem_addr"}, dmem_addr, addr);
                check({tag, "_dmem_mask"}, 32'(dmem_mask), 32'(exp_mask));
                if (we) check({tag, "_dmem_wr_data"}, dmem_wr_data, wd);
            end
            if (k == 1 && eerr != 2'b00) begin
                check({tag, "_fault_no_strobe"}, 32'({dmem_rd, dmem_wr}), 32'd0);
            end
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, rsp_rdata, e.rdata);
            check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
            for (int i = 0; i < hold; i++) begin
                req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
                req_addr = 32'h30; req_wdata = 32'hBAD0BAD0;
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
                check({tag, "_hold_rdata"}, rsp_rdata, e.rdata);
                check({tag, "_hold_err"}, 32'(rsp_err), 32'(e.err));
                check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
            end
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle_after"}, 32'({rsp_valid, req_ready}), 32'b01);
    endtask

    initial begin
        int         wr_before;
        logic [31:0] word_before;
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          wr_before;
        logic [31:0] word_before;
        n_cmp = 0; n_err = 0; wr_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
`ifdef LSU_PERF_CNT_EN
        n_load = 0; n_store = 0; n_fault = 0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        rst = 1'b0;

        // Word store then load back.
        issue("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 2'b00, 0);
        issue("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00, 0);

        // Sign/zero extension and sub-word stores.
        issue("sw_20", 1'b1, 3'b010, 32'h20, 32'h000080F0, 32'h0, 2'b00, 0);
        issue("lb_20", 1'b0, 3'b000, 32'h20, 32'h0, 32'hFFFFFFF0, 2'b00, 0);
        issue("lbu_20", 1'b0, 3'b100, 32'h20, 32'h0, 32'h000000F0, 2'b00, 0);
        issue("lh_20", 1'b0, 3'b001, 32'h20, 32'h0, 32'hFFFF80F0, 2'b00, 0);
        issue("lhu_20", 1'b0, 3'b101, 32'h20, 32'h0, 32'h000080F0, 2'b00, 0);
        issue("sb_23", 1'b1, 3'b000, 32'h23, 32'h000000AA, 32'h0, 2'b00, 0);
        issue("lw_20b", 1'b0, 3'b010, 32'h20, 32'h0, 32'hAA0080F0, 2'b00, 0);
        issue("lh_22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFFAA00, 2'b00, 0);
        issue("sh_26", 1'b1, 3'b001, 32'h26, 32'h00001234, 32'h0, 2'b00, 0);
        issue("lhu_26", 1'b0, 3'b101, 32'h26, 32'h0, 32'h00001234, 2'b00, 0);
        issue("sb_ff", 1'b1, 3'b000, 32'hFF, 32'h0000007F, 32'h0, 2'b00, 0);
        issue("lb_ff", 1'b0, 3'b000, 32'hFF, 32'h0, 32'h0000007F, 2'b00, 0);
        issue("lw_fc", 1'b0, 3'b010, 32'hFC, 32'h0, 32'h7F000000, 2'b00, 0);

        // Faults: no memory activity, error code by priority.
        wr_before   = wr_cnt;
        word_before = mem_word(32'h20);
        issue("lw_22", 1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 2'b01, 0);
        issue("sh_21", 1'b1, 3'b001, 32'h21, 32'hFFFF, 32'h0, 2'b01, 0);
        issue("lw_100", 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 2'b10, 0);
        issue("sw_100", 1'b1, 3'b010, 32'h100, 32'h1, 32'h0, 2'b10, 0);
        issue("lh_ff", 1'b0, 3'b001, 32'hFF, 32'h0, 32'h0, 2'b01, 0);
        issue("lh_101", 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 2'b01, 0);
        issue("f3_011", 1'b0, 3'b011, 32'h101, 32'h0, 32'h0, 2'b11, 0);
        issue("f3_110", 1'b0, 3'b110, 32'h20, 32'h0, 32'h0, 2'b11, 0);
        issue("sbu_20", 1'b1, 3'b100, 32'h20, 32'h55, 32'h0, 2'b11, 0);
        issue("lw_top", 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 2'b10, 0);
        check("fault_no_write", 32'(wr_cnt - wr_before), 32'd0);
        check("fault_mem_20", mem_word(32'h20), word_before);

        // Back-pressure with a stray store offered during RESP.
        word_before = mem_word(32'h30);
        wr_before   = wr_cnt;
        issue("lw_hold", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00, 5);
        check("hold_no_write", 32'(wr_cnt - wr_before), 32'd0);
        check("hold_mem_30", mem_word(32'h30), word_before);

        // Reset during ACCESS of a store, before its falling-edge write.
        issue("sw_30_old", 1'b1, 3'b010, 32'h30, 32'h11111111, 32'h0, 2'b00, 0);
        wr_before = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h30; req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("pre_rst_in_access", 32'(dmem_wr), 32'd1);
        rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
`ifdef LSU_PERF_CNT_EN
        n_load = 0; n_store = 0; n_fault = 0;
`endif
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_mem_30", mem_word(32'h30), 32'h11111111);
        check("rst_no_write", 32'(wr_cnt - wr_before), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Event mix after reset: 2 loads, 1 store, 1 fault.
        issue("perf_sw", 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 2'b00, 0);
        issue("perf_lw", 1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 2'b00, 0);
        issue("perf_lbu", 1'b0, 3'b100, 32'h43, 32'h0, 32'h000000CA, 2'b00, 0);
        issue("perf_flt", 1'b0, 3'b111, 32'h40, 32'h0, 32'h0, 2'b11, 0);
`ifdef LSU_PERF_CNT_EN
        check("load_cnt", 32'(load_cnt), 32'(n_load));
        check("store_cnt", 32'(store_cnt), 32'(n_store));
        check("fault_cnt", 32'(fault_cnt), 32'(n_fault));
        check("perf_expect", 32'({n_load[7:0], n_store[7:0], n_fault[7:0]}), 32'h020101);
`endif
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
